// File: rtl/rv32_irq_pkg.sv
// Shared types for the push-button interrupt request path.
package rv32_irq_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PENDING    = 2'd1,
    IN_SERVICE = 2'd2
  } irq_state_t;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises the raw button, filters bounce and emits a one-cycle press
// pulse registered alongside the rising debounced level.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic stable,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [CNT_W-1:0]       cnt;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  // cnt tracks consecutive samples disagreeing with stable; any agreement restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
        press  <= ~stable;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/irq_request_ctrl.sv
// Turns debounced button presses into a level interrupt request with a
// one-deep queue during service and a saturating count of lost presses.
//
// state      | meaning
// IDLE       | nothing pending, nothing in service
// PENDING    | request raised (gated by irq_en), waiting for irq_ack
// IN_SERVICE | handler running, waiting for irq_done; one press may queue
module irq_request_ctrl
  import rv32_irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn,
  input  logic                  irq_en,
  input  logic                  irq_ack,
  input  logic                  irq_done,
  output logic                  irq,
  output logic                  btn1,
  output logic                  iled,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  irq_state_t state, state_nxt;
  logic       queued, queued_nxt;
  logic       drop_inc;
  logic       press;
  logic       irq_en_q;

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn),
    .stable (btn1),
    .press  (press)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      queued   <= 1'b0;
      drop_cnt <= '0;
      irq_en_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      queued   <= queued_nxt;
      irq_en_q <= irq_en;
      if (drop_inc && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  // a press arriving with irq_done is queued before the exit decision
  always_comb begin
    state_nxt  = state;
    queued_nxt = queued;
    drop_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (press) state_nxt = PENDING;
      end
      PENDING: begin
        if (irq_ack) begin
          state_nxt  = IN_SERVICE;
          queued_nxt = press;
        end else if (press) begin
          drop_inc = 1'b1;
        end
      end
      IN_SERVICE: begin
        if (press) begin
          if (queued) drop_inc = 1'b1;
          else        queued_nxt = 1'b1;
        end
        if (irq_done) begin
          state_nxt  = queued_nxt ? PENDING : IDLE;
          queued_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        queued_nxt = 1'b0;
      end
    endcase
  end

  // enable is taken through a flop so no input reaches an output combinationally
  always_comb begin
    irq  = (state == PENDING) && irq_en_q;
    iled = (state != IDLE);
  end

endmodule
